// File: rtl/gbf_pkg.sv
// Shared types and constants for the global-buffer ping-pong controller.
package gbf_pkg;

  localparam int GBF_DATA_W     = 512;
  localparam int GBF_ADDR_W     = 5;
  localparam int GBF_DEPTH      = 32;
  localparam int GBF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bank_st_e;

  // A bank holds unread data once it is closed until its last word leaves.
  function automatic logic holds_data(input bank_st_e s);
    return (s == FULL) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/gbf_pingpong_ctrl_if.sv
// Loader stream, feeder stream and RAM port bundles of the ping-pong controller.
// GBF_REPLAY_EN adds the rd_repeat pass-count input.
interface gbf_pingpong_ctrl_if #(
  parameter int DATA_BITWIDTH = 512,
  parameter int ADDR_BITWIDTH = 5
);
  logic                     wr_valid;
  logic                     wr_ready;
  logic [DATA_BITWIDTH-1:0] wr_data;
  logic                     wr_last;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [DATA_BITWIDTH-1:0] rd_data;
  logic                     rd_last;
  logic [1:0]               ram_ena;
  logic [1:0]               ram_wea;
  logic [ADDR_BITWIDTH-1:0] ram_addra;
  logic [DATA_BITWIDTH-1:0] ram_dia;
  logic [1:0]               ram_enb;
  logic [ADDR_BITWIDTH-1:0] ram_addrb;
  logic [DATA_BITWIDTH-1:0] ram_dob0;
  logic [DATA_BITWIDTH-1:0] ram_dob1;
  logic [1:0]               bank_full;
`ifdef GBF_REPLAY_EN
  logic [7:0]               rd_repeat;
`endif

  modport master (
    input  wr_valid, wr_data, wr_last, rd_ready, ram_dob0, ram_dob1,
`ifdef GBF_REPLAY_EN
    input  rd_repeat,
`endif
    output wr_ready, rd_valid, rd_data, rd_last,
    output ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb, bank_full
  );

  modport slave (
    output wr_valid, wr_data, wr_last, rd_ready, ram_dob0, ram_dob1,
`ifdef GBF_REPLAY_EN
    output rd_repeat,
`endif
    input  wr_ready, rd_valid, rd_data, rd_last,
    input  ram_ena, ram_wea, ram_addra, ram_dia, ram_enb, ram_addrb, bank_full
  );
endinterface

// File: rtl/gbf_out_fifo.sv
// Two-entry registered output FIFO; e0 is always the head.
module gbf_out_fifo #(
  parameter int W = 513
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] e0, e1;
  logic [1:0]   cnt;

  // Shift-style storage: pushes fill the first free slot, pops move e1 to head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = e0;
  assign count = cnt;
endmodule

// File: rtl/gbf_pingpong_ctrl.sv
// Ping-pong controller for a pair of global-buffer banks: one bank fills from
// the loader stream while the other drains to the array feeder.
// GBF_REPLAY_EN: each closed bank is drained rd_repeat+1 times.
module gbf_pingpong_ctrl
  import gbf_pkg::*;
#(
  parameter int DATA_BITWIDTH = GBF_DATA_W,
  parameter int ADDR_BITWIDTH = GBF_ADDR_W,
  parameter int DEPTH         = GBF_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  gbf_pingpong_ctrl_if.master bus
);
  localparam int LW = ADDR_BITWIDTH + 1;

  bank_st_e                 st_q [2];
  bank_st_e                 st_d [2];
  logic                     wsel, rsel, rdone;
  logic [ADDR_BITWIDTH-1:0] wcnt, rcnt;
  logic [1:0][LW-1:0]       len_q;

  logic wr_rdy, wr_fire, wr_close;
  logic rd_active, rd_issue, iss_last, rd_pop, pop_last, bank_done, pass_more;
  logic [1:0]               fifo_cnt;
  logic [DATA_BITWIDTH:0]   fifo_dout;

`ifdef GBF_REPLAY_EN
  logic [7:0] pass_left, last_left, pass_cur;
`endif

  // Handshake, close and read-issue decisions.
  always_comb begin
    wr_rdy    = (st_q[wsel] == EMPTY) || (st_q[wsel] == FILL);
    wr_fire   = bus.wr_valid && wr_rdy;
    wr_close  = wr_fire && ((wcnt == ADDR_BITWIDTH'(DEPTH - 1)) || bus.wr_last);
    rd_active = holds_data(st_q[rsel]);
    rd_pop    = (fifo_cnt != 2'd0) && bus.rd_ready;
    // Read data lands in the FIFO at the edge ending the issue cycle, so the
    // only in-flight word is the one being issued now.
    rd_issue  = rd_active && !rdone && ((fifo_cnt < 2'(GBF_FIFO_DEPTH)) || rd_pop);
    iss_last  = rd_issue && ({1'b0, rcnt} == (len_q[rsel] - LW'(1)));
    pop_last  = rd_pop && fifo_dout[DATA_BITWIDTH];
`ifdef GBF_REPLAY_EN
    // rd_repeat is live during the FULL cycle, before it is captured.
    pass_cur  = (st_q[rsel] == FULL) ? bus.rd_repeat : pass_left;
    pass_more = (pass_cur != 8'd0);
    bank_done = pop_last && (last_left == 8'd0);
`else
    pass_more = 1'b0;
    bank_done = pop_last;
`endif
  end

  // Bank state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= '{EMPTY, EMPTY};
    else     st_q <= st_d;
  end

  // Bank next state: writer and reader always act on different banks.
  always_comb begin
    st_d = st_q;
    if (wr_fire)               st_d[wsel] = wr_close ? FULL : FILL;
    if (st_q[rsel] == FULL)    st_d[rsel] = DRAIN;
    if (bank_done)             st_d[rsel] = EMPTY;
  end

  // RAM port and stream outputs.
  always_comb begin
    bus.wr_ready       = wr_rdy;
    bus.ram_ena        = '0;
    bus.ram_wea        = '0;
    bus.ram_ena[wsel]  = wr_fire;
    bus.ram_wea[wsel]  = wr_fire;
    bus.ram_addra      = wcnt;
    bus.ram_dia        = bus.wr_data;
    bus.ram_enb        = '0;
    bus.ram_enb[rsel]  = rd_issue;
    bus.ram_addrb      = rcnt;
    bus.bank_full[0]   = holds_data(st_q[0]);
    bus.bank_full[1]   = holds_data(st_q[1]);
    bus.rd_valid       = (fifo_cnt != 2'd0);
    bus.rd_data        = fifo_dout[DATA_BITWIDTH-1:0];
    bus.rd_last        = fifo_dout[DATA_BITWIDTH];
  end

  // Write/read pointers, counters and captured bank lengths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsel  <= 1'b0;
      rsel  <= 1'b0;
      wcnt  <= '0;
      rcnt  <= '0;
      rdone <= 1'b0;
      len_q <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_close) begin
          len_q[wsel] <= {1'b0, wcnt} + LW'(1);
          wcnt        <= '0;
          wsel        <= ~wsel;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (bank_done) begin
        rsel  <= ~rsel;
        rcnt  <= '0;
        rdone <= 1'b0;
      end else if (rd_issue) begin
        if (iss_last) begin
          if (pass_more) rcnt  <= '0;
          else           rdone <= 1'b1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end
  end

`ifdef GBF_REPLAY_EN
  // Remaining issue passes and remaining end-of-pass pops for the read bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_left <= '0;
      last_left <= '0;
    end else begin
      if (iss_last && pass_more)      pass_left <= pass_cur - 8'd1;
      else if (st_q[rsel] == FULL)    pass_left <= bus.rd_repeat;
      if (st_q[rsel] == FULL)         last_left <= bus.rd_repeat;
      else if (pop_last && last_left != 8'd0) last_left <= last_left - 8'd1;
    end
  end
`endif

  // Read data selected by rsel, which is stable across the issue cycle.
  gbf_out_fifo #(.W(DATA_BITWIDTH + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_issue),
    .din   ({iss_last, (rsel ? bus.ram_dob1 : bus.ram_dob0)}),
    .pop   (rd_pop),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_gbf_pingpong_ctrl.sv
// Directed bench for gbf_pingpong_ctrl with a negedge RAM pair model.
module tb_gbf_pingpong_ctrl;
  localparam int DW = 512;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   nchk = 0, nfail = 0;

  gbf_pingpong_ctrl_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW)) bus ();

  gbf_pingpong_ctrl #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .DEPTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem0 [32];
  logic [DW-1:0] mem1 [32];
  always @(negedge clk) begin
    if (bus.ram_ena[0] && bus.ram_wea[0]) mem0[bus.ram_addra] <= bus.ram_dia;
    if (bus.ram_ena[1] && bus.ram_wea[1]) mem1[bus.ram_addra] <= bus.ram_dia;
    if (bus.ram_enb[0]) bus.ram_dob0 <= mem0[bus.ram_addrb];
    if (bus.ram_enb[1]) bus.ram_dob1 <= mem1[bus.ram_addrb];
  end

  logic [DW:0]   q [$];
  int            bcnt, npop, first_vld, hs_cyc;
  logic          held, hold_last, wdone;
  logic [DW-1:0] hold_data;
  logic [1:0]    last_ena;
  logic [AW-1:0] last_addra;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] v);
    return {16{v}};
  endfunction

  // Monitor: scoreboard pops, hold stability, wr_ready/bank_full relation.
  initial begin
    logic [DW:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("wr_ready_rel", 512'(bus.wr_ready), 512'(bus.bank_full != 2'b11));
        if (held) begin
          chk("hold_valid", 512'(bus.rd_valid), 512'(1));
          chk("hold_data", bus.rd_data, hold_data);
          chk("hold_last", 512'(bus.rd_last), 512'(hold_last));
        end
        held      = bus.rd_valid && !bus.rd_ready;
        hold_data = bus.rd_data;
        hold_last = bus.rd_last;
        if (bus.rd_valid && first_vld < 0) first_vld = cyc;
        if (bus.rd_valid && bus.rd_ready) begin
          if (q.size() == 0) chk("extra_word", bus.rd_data, '0);
          else begin
            e = q.pop_front();
            chk("rd_data", bus.rd_data, e[DW-1:0]);
            chk("rd_last", 512'(bus.rd_last), 512'(e[DW]));
          end
          npop++;
        end
      end
    end
  end

  task automatic clr_model();
    q.delete();
    bcnt = 0; npop = 0; first_vld = -1; held = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clr_model();
  endtask

  task automatic put(input logic [31:0] v, input logic wl);
    logic ok, el;
    bus.wr_valid = 1'b1; bus.wr_data = mk(v); bus.wr_last = wl;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (bus.wr_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wr_timeout", 512'(0), 512'(1));
    else begin
      el = wl || (bcnt == 31);
      bcnt = el ? 0 : bcnt + 1;
      hs_cyc = cyc; last_ena = bus.ram_ena; last_addra = bus.ram_addra;
      q.push_back({el, mk(v)});
    end
    @(posedge clk);
    #1 bus.wr_valid = 1'b0; bus.wr_last = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int n);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.rd_valid) begin ok = 1'b1; break; end
    end
    chk({tag, "_drained"}, 512'(ok), 512'(1));
    chk({tag, "_npop"}, 512'(npop), 512'(n));
    chk({tag, "_bank_full"}, 512'(bus.bank_full), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
`ifdef GBF_REPLAY_EN
    bus.rd_repeat = 8'd0;
`endif
    do_reset();
    #1;
    chk("rst_wr_ready", 512'(bus.wr_ready), 512'(1));
    chk("rst_rd_valid", 512'(bus.rd_valid), 512'(0));
    chk("rst_rd_last", 512'(bus.rd_last), 512'(0));
    chk("rst_rd_data", bus.rd_data, '0);
    chk("rst_ram_ena", 512'({bus.ram_ena, bus.ram_wea}), 512'(0));
    chk("rst_ram_enb", 512'(bus.ram_enb), 512'(0));
    chk("rst_addr", 512'({bus.ram_addra, bus.ram_addrb}), 512'(0));
    chk("rst_bank_full", 512'(bus.bank_full), 512'(0));

    // 32 words fill bank 0, drain in order with 2-cycle close latency.
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 32; i++) put(32'(i), 1'b0);
    wait_drain("t1", 32);
    chk("t1_latency", 512'(first_vld - hs_cyc), 512'(2));

    // 96-word continuous stream alternates banks 0,1,0.
    do_reset();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 96; i++) begin
      put(32'h100 + 32'(i), 1'b0);
      chk("t2_bank", 512'(last_ena), 512'(2'b01 << ((i / 32) % 2)));
      chk("t2_addr", 512'(last_addra), 512'(i % 32));
    end
    wait_drain("t2", 96);

    // Early close on the 5th word; the next word opens bank 1 at address 0.
    do_reset();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) put(32'hA0 + 32'(i), i == 4);
    chk("t3_bank0", 512'(last_ena), 512'(2'b01));
    put(32'hB0, 1'b1);
    chk("t3_next_bank", 512'(last_ena), 512'(2'b10));
    chk("t3_next_addr", 512'(last_addra), 512'(0));
    wait_drain("t3", 6);

    // Random back-pressure over 64 words.
    do_reset();
    wdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 64; i++) put(32'h200 + 32'(i), 1'b0);
        wdone = 1'b1;
      end
      begin
        for (int t = 0; t < 4000 && !(wdone && q.size() == 0); t++) begin
          @(posedge clk);
          #1 bus.rd_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.rd_ready = 1'b1;
    wait_drain("t4", 64);

    // Reset pulse mid-drain.
    do_reset();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 32; i++) put(32'h300 + 32'(i), 1'b0);
    for (int t = 0; t < 200 && npop < 10; t++) @(negedge clk);
    chk("t5_reached10", 512'(npop >= 10), 512'(1));
    rst = 1'b1;
    #1;
    chk("t5_rd_valid", 512'(bus.rd_valid), 512'(0));
    chk("t5_rd_last", 512'(bus.rd_last), 512'(0));
    chk("t5_bank_full", 512'(bus.bank_full), 512'(0));
    chk("t5_wr_ready", 512'(bus.wr_ready), 512'(1));
    chk("t5_ram_enb", 512'(bus.ram_enb), 512'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    clr_model();
    put(32'h3C0, 1'b1);
    chk("t5_next_bank", 512'(last_ena), 512'(2'b01));
    chk("t5_next_addr", 512'(last_addra), 512'(0));
    wait_drain("t5", 1);

`ifdef GBF_REPLAY_EN
    // Three passes over a 4-word bank.
    do_reset();
    bus.rd_repeat = 8'd2;
    bus.rd_ready  = 1'b1;
    for (int i = 0; i < 4; i++) put(32'h400 + 32'(i), i == 3);
    for (int p = 1; p < 3; p++)
      for (int i = 0; i < 4; i++) q.push_back({(i == 3), mk(32'h400 + 32'(i))});
    wait_drain("t6", 12);
    bus.rd_repeat = 8'd0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
